// File: rtl/arg_num_accum.sv
`default_nettype none
// ============================================================================
// Module      : arg_num_accum
// Description : Accumulates one signed decimal G-code argument from a stream
//               of ASCII characters and presents it as a MAX_ARG_BITS-wide
//               two's complement value with valid/overflow flags.
//               Optional build macro ARG_SATURATE_EN: overflowed arguments
//               saturate to the signed range limit instead of reading as 0.
// Revision    : 1.0 - initial release
// ============================================================================
module arg_num_accum #(
    parameter int MAX_ARG_BITS = 12,
    parameter int MAX_DIGITS   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    output logic [MAX_ARG_BITS-1:0] num,
    output logic                    num_valid,
    input  logic                    num_ready,
    output logic                    is_valid,
    output logic                    overflow
);

    // Accumulator carries 4 spare bits so acc*10+digit never wraps before
    // the limit compare (acc itself never exceeds 2^(MAX_ARG_BITS-1)).
    localparam int c_ACC_W = MAX_ARG_BITS + 4;
    localparam int c_CNT_W = $clog2(MAX_DIGITS + 2);

    localparam logic [c_ACC_W-1:0] c_LIM_POS = c_ACC_W'((64'd1 << (MAX_ARG_BITS - 1)) - 64'd1);
    localparam logic [c_ACC_W-1:0] c_LIM_NEG = c_ACC_W'(64'd1 << (MAX_ARG_BITS - 1));
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIGN_SEEN = 2'd1,
        DIGITS    = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_ACC_W-1:0]   r_acc,   w_acc_nxt;
    logic                 r_neg,   w_neg_nxt;
    logic                 r_ovf,   w_ovf_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic                 r_run;

    logic                 w_xfer_in;
    logic                 w_is_digit;
    logic [c_ACC_W-1:0]   w_digit;
    logic [c_ACC_W-1:0]   w_limit;
    logic [c_ACC_W-1:0]   w_cand;
    logic                 w_digit_ovf;
    logic [MAX_ARG_BITS-1:0] w_mag;
    logic [MAX_ARG_BITS-1:0] w_sat;
    logic                 w_sat_en;

`ifdef ARG_SATURATE_EN
    assign w_sat_en = 1'b1;
`else
    assign w_sat_en = 1'b0;
`endif

    assign w_xfer_in  = char_valid & char_ready;
    assign w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign w_digit    = {{(c_ACC_W-4){1'b0}}, char_in[3:0]};
    assign w_limit    = r_neg ? c_LIM_NEG : c_LIM_POS;
    // acc is zero before the first digit, so the same expression loads it.
    assign w_cand     = (r_acc << 3) + (r_acc << 1) + w_digit;
    assign w_digit_ovf = (r_cnt >= c_CNT_MAX) || (w_cand > w_limit);

    // Holds char_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_neg   <= w_neg_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and accumulator update for each consumed character.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_neg_nxt   = r_neg;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, SIGN_SEEN, DIGITS: begin
                if (w_xfer_in) begin
                    if (w_is_digit) begin
                        w_state_nxt = DIGITS;
                        if (r_cnt != c_CNT_SAT) w_cnt_nxt = r_cnt + 1'b1;
                        // Once overflowed, acc stays frozen; digits are
                        // still swallowed so the terminator is found.
                        if (r_ovf || w_digit_ovf) w_ovf_nxt = 1'b1;
                        else                      w_acc_nxt = w_cand;
                    end else if (r_state == IDLE) begin
                        if (char_in == 8'h2D) begin
                            w_neg_nxt   = 1'b1;
                            w_state_nxt = SIGN_SEEN;
                        end else if (char_in == 8'h2B) begin
                            w_state_nxt = SIGN_SEEN;
                        end
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (num_ready) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_neg_nxt   = 1'b0;
                    w_ovf_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_mag = r_acc[MAX_ARG_BITS-1:0];
    assign w_sat = r_neg ? {1'b1, {(MAX_ARG_BITS-1){1'b0}}}
                         : {1'b0, {(MAX_ARG_BITS-1){1'b1}}};

    // Result presentation; everything reads zero outside DONE.
    always_comb begin
        char_ready = r_run && (r_state != DONE);
        num_valid  = (r_state == DONE);
        overflow   = 1'b0;
        is_valid   = 1'b0;
        num        = '0;
        if (r_state == DONE) begin
            overflow = r_ovf;
            if (r_cnt == '0) begin
                is_valid = 1'b0;
            end else if (r_ovf) begin
                is_valid = w_sat_en;
                num      = w_sat_en ? w_sat : '0;
            end else begin
                is_valid = 1'b1;
                num      = r_neg ? (~w_mag + 1'b1) : w_mag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arg_num_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_arg_num_accum
// Description : Self-checking bench for arg_num_accum (MAX_ARG_BITS=12,
//               MAX_DIGITS=8). Honours ARG_SATURATE_EN for expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arg_num_accum;

    localparam int N = 12;

`ifdef ARG_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   char_in;
    logic         char_valid;
    logic         char_ready;
    logic [N-1:0] num;
    logic         num_valid;
    logic         num_ready;
    logic         is_valid;
    logic         overflow;

    int n_vec  = 0;
    int n_miss = 0;

    arg_num_accum #(.MAX_ARG_BITS(N), .MAX_DIGITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .num        (num),
        .num_valid  (num_valid),
        .num_ready  (num_ready),
        .is_valid   (is_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        s;
        logic [N-1:0] e_num;
        bit           e_val;
        bit           e_ovf;
    } vec_t;

    vec_t tab[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one character; returns at posedge+1 of the edge that took it.
    task automatic send_char(input logic [7:0] c);
        int guard;
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        guard      = 0;
        while (!char_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!char_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL char_accept timeout: got char_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic take_result();
        @(negedge clk);
        num_ready = 1'b1;
        @(posedge clk);
        #1;
        num_ready = 1'b0;
        chk("num_valid_after_take", {31'd0, num_valid}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] e_num,
                                input bit e_val, input bit e_ovf);
        chk({tag, " num_valid"}, {31'd0, num_valid}, 32'd1);
        chk({tag, " num"},       {20'd0, num},       {20'd0, e_num});
        chk({tag, " is_valid"},  {31'd0, is_valid},  {31'd0, e_val});
        chk({tag, " overflow"},  {31'd0, overflow},  {31'd0, e_ovf});
    endtask

    initial begin
        tab[0]  = '{"2047 ",        12'd2047,  1'b1, 1'b0};
        tab[1]  = '{"-2048\n",      12'h800,   1'b1, 1'b0};
        tab[2]  = '{"-0 ",          12'h000,   1'b1, 1'b0};
        tab[3]  = '{"2048 ",        SAT ? 12'h7FF : 12'h000, SAT, 1'b1};
        tab[4]  = '{"-2049 ",       SAT ? 12'h800 : 12'h000, SAT, 1'b1};
        tab[5]  = '{"- ",           12'h000,   1'b0, 1'b0};
        tab[6]  = '{"123456789 ",   SAT ? 12'h7FF : 12'h000, SAT, 1'b1};
        tab[7]  = '{"00002047 ",    12'd2047,  1'b1, 1'b0};
        tab[8]  = '{"000000001 ",   SAT ? 12'h7FF : 12'h000, SAT, 1'b1};
        tab[9]  = '{"x12;",         12'd12,    1'b1, 1'b0};
        tab[10] = '{"+5 ",          12'd5,     1'b1, 1'b0};
        tab[11] = '{"-2047 ",       12'h801,   1'b1, 1'b0};

        reset      = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        num_ready  = 1'b0;

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst char_ready", {31'd0, char_ready}, 32'd0);
        chk("rst num_valid",  {31'd0, num_valid},  32'd0);
        chk("rst num",        {20'd0, num},        32'd0);
        chk("rst is_valid",   {31'd0, is_valid},   32'd0);
        chk("rst overflow",   {31'd0, overflow},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst char_ready", {31'd0, char_ready}, 32'd1);

        // Table vectors; num_valid is checked right after the terminator edge.
        for (int v = 0; v < 12; v++) begin
            send_str(tab[v].s);
            check_result($sformatf("vec%0d", v), tab[v].e_num, tab[v].e_val, tab[v].e_ovf);
            take_result();
        end

        // num_ready held 0 for 5 cycles: result and back-pressure must hold.
        send_str("100 ");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold char_ready", {31'd0, char_ready}, 32'd0);
            check_result("hold", 12'd100, 1'b1, 1'b0);
        end
        take_result();
        send_str("-100 ");
        check_result("after_hold", 12'hF9C, 1'b1, 1'b0);
        take_result();

        // num_ready while nothing is pending must not disturb the block.
        @(negedge clk);
        num_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready num_valid", {31'd0, num_valid},  32'd0);
        chk("idle_ready char_ready", {31'd0, char_ready}, 32'd1);
        num_ready = 1'b0;
        send_str("3 ");
        check_result("idle_ready", 12'd3, 1'b1, 1'b0);
        take_result();

        // Reset mid-argument discards the partial value.
        send_str("12");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst num_valid",  {31'd0, num_valid},  32'd0);
        chk("midrst char_ready", {31'd0, char_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rel char_ready", {31'd0, char_ready}, 32'd1);
        send_str("7 ");
        check_result("after_midrst", 12'd7, 1'b1, 1'b0);

        // Reset while a result is pending drops it.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("donerst num_valid", {31'd0, num_valid}, 32'd0);
        chk("donerst num",       {20'd0, num},       32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_str("9 ");
        check_result("after_donerst", 12'd9, 1'b1, 1'b0);
        take_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arg_num_accum.md
ARG_NUM_ACCUM -- requirements
Module: arg_num_accum

Interface
REQ-001 Parameter MAX_ARG_BITS, default 12, output argument width in bits (two's complement); legal range 4..24.
REQ-002 Parameter MAX_DIGITS, default 8, maximum decimal digits accepted per argument before forced overflow.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 char_in  input  8  ASCII character from the G-code lexer.
REQ-006 char_valid  input  1  char_in is presented.
REQ-007 char_ready  output  1  block accepts char_in this cycle; a transfer occurs when char_valid and char_ready are both 1.
REQ-008 num  output  MAX_ARG_BITS  signed argument result.
REQ-009 num_valid  output  1  num, is_valid and overflow are presented.
REQ-010 num_ready  input  1  consumer accepts the result; a transfer occurs when num_valid and num_ready are both 1.
REQ-011 is_valid  output  1  num is in range and well formed.
REQ-012 overflow  output  1  magnitude exceeded the signed MAX_ARG_BITS range, or more than MAX_DIGITS digits were received.

Function
REQ-013 The FSM SHALL have four states: IDLE, SIGN_SEEN, DIGITS and DONE.
REQ-014 IDLE: '-' SHALL set neg and move to SIGN_SEEN; '+' SHALL move to SIGN_SEEN; a digit '0'..'9' SHALL load acc=digit and move to DIGITS; any other character SHALL be consumed and ignored.
REQ-015 SIGN_SEEN: a digit SHALL load acc and move to DIGITS; any non-digit SHALL be consumed as terminator and move to DONE with is_valid=0 and overflow=0 (empty argument).
REQ-016 DIGITS: a digit SHALL set acc=acc*10+digit; any non-digit SHALL be consumed as terminator and move to DONE.
REQ-017 The limit SHALL be 2^(MAX_ARG_BITS-1)-1 when neg=0 and 2^(MAX_ARG_BITS-1) when neg=1; acc held unsigned at MAX_ARG_BITS+4 bits.
REQ-018 When an update would exceed the limit, or when the digit count exceeds MAX_DIGITS, the block SHALL set ovf sticky and freeze acc; later digits SHALL still be consumed.
REQ-019 char_ready SHALL be 1 in IDLE, SIGN_SEEN and DIGITS, and 0 in DONE; a character is consumed exactly once.
REQ-020 num_valid SHALL assert in the cycle after the terminator transfer and hold, with num, is_valid and overflow stable, until num_ready is sampled 1.
REQ-021 A num transfer SHALL return the block to IDLE and clear acc, neg, ovf and the digit count; the next character is accepted in the following cycle.
REQ-022 In the non-overflow case, num SHALL equal neg ? -acc : acc, truncated to MAX_ARG_BITS, and is_valid SHALL be 1.
REQ-023 "-0" SHALL yield num=0 with is_valid=1.
REQ-024 num_ready asserted while num_valid=0 SHALL have no effect.

Reset
REQ-025 While reset=0, the block SHALL be in IDLE with acc=0, neg=0, ovf=0, digit count=0, num=0, num_valid=0, is_valid=0, overflow=0 and char_ready=0.
REQ-026 Reset asserted mid-argument or in DONE SHALL discard the partial or pending result; after release, char_ready SHALL be 1 on the first clock edge.

Configuration
REQ-027 With ARG_SATURATE_EN defined, an overflow result SHALL give num = +2^(MAX_ARG_BITS-1)-1, or -2^(MAX_ARG_BITS-1) when neg=1, with overflow=1 and is_valid=1.
REQ-028 Without ARG_SATURATE_EN, an overflow result SHALL give num=0, overflow=1 and is_valid=0.

Verification (MAX_ARG_BITS=12, MAX_DIGITS=8)
REQ-029 Input "2047 " with num_ready=1 -> num=2047, is_valid=1, overflow=0; num_valid asserts 1 cycle after the space is accepted.
REQ-030 Inputs "-2048\n" and "-0 " -> num=0x800 with is_valid=1, then num=0 with is_valid=1.
REQ-031 Inputs "2048 " and "-2049 " -> overflow=1 for both; num=2047 and num=-2048 with is_valid=1 when ARG_SATURATE_EN is defined, else num=0 with is_valid=0.
REQ-032 Inputs "- " and "123456789 " -> first gives is_valid=0 with overflow=0; second gives overflow=1.
REQ-033 Input "100 -100 " with num_ready held 0 for 5 cycles -> char_ready=0 and num=100 stable throughout; after the transfer, num=-100 follows.
REQ-034 reset pulsed low after "12" -> num_valid=0; after release, input "7 " -> num=7 (no residue from 12).
